// File: rtl/frac_reduce_if.sv
// Signal bundle for frac_reduce: input pair, GCD engine request/response, reduced output.
// The slave modport is the reducer's view; master is the surrounding system's view.
interface frac_reduce_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         gcd_start;
  logic [W-1:0] gcd_ina;
  logic [W-1:0] gcd_inb;
  logic         gcd_ready;
  logic [W-1:0] gcd_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic         out_err;

  modport slave (
    input  in_valid, num, den, gcd_ready, gcd_out, out_ready,
    output in_ready, gcd_start, gcd_ina, gcd_inb, out_valid, out_num, out_den, out_err
  );

  modport master (
    output in_valid, num, den, gcd_ready, gcd_out, out_ready,
    input  in_ready, gcd_start, gcd_ina, gcd_inb, out_valid, out_num, out_den, out_err
  );
endinterface

// File: rtl/frac_reduce.sv
// Fraction reducer: requests gcd(num, den) from the GCD engine, then divides both
// operands by it on one shared W-cycle restoring divider; zero operands bypass the engine.
module frac_reduce #(
  parameter int W = 8
) (
  input logic          clk,
  input logic          nrst,
  frac_reduce_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD_START,
    S_GCD_WAIT,
    S_DIV_NUM,
    S_DIV_DEN,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  g_q, g_d;
  logic [W-1:0]  ina_q, ina_d;
  logic [W-1:0]  inb_q, inb_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  onum_q, onum_d;
  logic [W-1:0]  oden_q, oden_d;
  logic          oerr_q, oerr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    trial;
  logic [W:0]    diff;
  logic [W-1:0]  step_rem;
  logic [W-1:0]  step_quo;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      g_q     <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      onum_q  <= '0;
      oden_q  <= '0;
      oerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      g_q     <= g_d;
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      onum_q  <= onum_d;
      oden_q  <= oden_d;
      oerr_q  <= oerr_d;
      cnt_q   <= cnt_d;
    end
  end

  // One restoring step: the borrow out of the trial subtraction is the inverted quotient bit.
  always_comb begin
    trial    = {rem_q, quo_q[W-1]};
    diff     = trial - {1'b0, g_q};
    step_rem = diff[W] ? trial[W-1:0] : diff[W-1:0];
    step_quo = {quo_q[W-2:0], ~diff[W]};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    g_d     = g_q;
    ina_d   = ina_q;
    inb_d   = inb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    onum_d  = onum_q;
    oden_d  = oden_q;
    oerr_d  = oerr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          n_d    = bus.num;
          d_d    = bus.den;
          oerr_d = 1'b0;
          if (bus.den == '0) begin
            onum_d  = bus.num;
            oden_d  = '0;
            oerr_d  = 1'b1;
            state_d = S_OUT;
          end else if (bus.num == '0) begin
            onum_d  = '0;
            oden_d  = W'(1);
            state_d = S_OUT;
          end else begin
            ina_d   = bus.num;
            inb_d   = bus.den;
            state_d = S_GCD_START;
          end
        end
      end
      S_GCD_START: begin
        cnt_d   = '0;
        state_d = S_GCD_WAIT;
      end
      S_GCD_WAIT: begin
        // cnt_q==0 marks the first wait cycle, where ready still reflects the pre-start engine.
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (bus.gcd_ready) begin
          g_d     = bus.gcd_out;
          quo_d   = n_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV_NUM;
        end
      end
      S_DIV_NUM: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          onum_d  = step_quo;
          quo_d   = d_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV_DEN;
        end
      end
      S_DIV_DEN: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          oden_d  = step_quo;
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.gcd_start = (state_q == S_GCD_START);
  assign bus.gcd_ina   = ina_q;
  assign bus.gcd_inb   = inb_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_num   = onum_q;
  assign bus.out_den   = oden_q;
  assign bus.out_err   = oerr_q;
endmodule

// File: tb/tb_frac_reduce.sv
// Scoreboard bench for frac_reduce with a behavioural GCD engine that answers 4 wait cycles after start.
module tb_frac_reduce;
  localparam int W = 8;

  typedef struct {
    int num;
    int den;
    int err;
    int lat;
  } exp_t;

  typedef struct {
    int a;
    int b;
  } gexp_t;

  logic clk;
  logic nrst;

  frac_reduce_if #(.W(W)) bus ();

  frac_reduce #(.W(W)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     starts = 0;
  int     exp_starts = 0;
  exp_t   exp_q[$];
  gexp_t  gexp_q[$];
  int     acc_q[$];
  bit     in_out = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural GCD engine: ready drops on the start edge and returns for the 4th wait cycle.
  logic         g_ready;
  logic [W-1:0] g_res;
  logic [2:0]   g_cnt;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      g_ready <= 1'b1;
      g_res   <= '0;
      g_cnt   <= '0;
    end else if (bus.gcd_start) begin
      g_ready <= 1'b0;
      g_res   <= gcd_fn(bus.gcd_ina, bus.gcd_inb);
      g_cnt   <= 3'd3;
    end else if (g_cnt != 0) begin
      g_cnt <= g_cnt - 3'd1;
      if (g_cnt == 3'd1) g_ready <= 1'b1;
    end
  end

  assign bus.gcd_ready = g_ready;
  assign bus.gcd_out   = g_res;

  always @(posedge clk) cyc++;

  // Monitor: GCD requests, accepts, first-valid latency, stall stability and output handshakes.
  always @(negedge clk) begin
    if (!nrst) begin
      acc_q.delete();
      in_out = 1'b0;
    end else begin
      if (bus.gcd_start) begin
        starts++;
        if (gexp_q.size() == 0) begin
          chk("gcd_start_unexpected", 1, 0);
        end else begin
          gexp_t ge;
          ge = gexp_q.pop_front();
          chk("gcd_ina", int'(bus.gcd_ina), ge.a);
          chk("gcd_inb", int'(bus.gcd_inb), ge.b);
        end
      end
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q[0];
          if (!in_out) begin
            in_out = 1'b1;
            if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
            else chk("latency", cyc - acc_q.pop_front(), e.lat);
          end
          chk("in_ready_during_out", int'(bus.in_ready), 0);
          if (!bus.out_ready) begin
            chk("stall_num", int'(bus.out_num), e.num);
            chk("stall_den", int'(bus.out_den), e.den);
            chk("stall_err", int'(bus.out_err), e.err);
          end else begin
            e = exp_q.pop_front();
            chk("out_num", int'(bus.out_num), e.num);
            chk("out_den", int'(bus.out_den), e.den);
            chk("out_err", int'(bus.out_err), e.err);
            in_out = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input int n, input int d, input int en, input int ed, input int ee,
                      input bit hold);
    bit ok;
    exp_t e;
    gexp_t g;
    e.num = en;
    e.den = ed;
    e.err = ee;
    e.lat = (n != 0 && d != 0) ? (1 + 4 + 2 * W + 1) : 1;
    exp_q.push_back(e);
    if (n != 0 && d != 0) begin
      g.a = n;
      g.b = d;
      gexp_q.push_back(g);
      exp_starts++;
    end
    bus.in_valid = 1'b1;
    bus.num      = W'(n);
    bus.den      = W'(d);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_gcd_start", int'(bus.gcd_start), 0);
    chk("rst_gcd_ina", int'(bus.gcd_ina), 0);
    chk("rst_gcd_inb", int'(bus.gcd_inb), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_num", int'(bus.out_num), 0);
    chk("rst_out_den", int'(bus.out_den), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    send(12, 18, 2, 3, 0, 1'b0);
    wait_idle();
    send(7, 7, 1, 1, 0, 1'b0);
    wait_idle();
    send(255, 17, 15, 1, 0, 1'b0);
    wait_idle();
    send(255, 255, 1, 1, 0, 1'b0);
    wait_idle();
    send(1, 255, 1, 255, 0, 1'b0);
    wait_idle();
    send(0, 5, 0, 1, 0, 1'b0);
    wait_idle();
    send(5, 0, 5, 0, 1, 1'b0);
    wait_idle();
    send(0, 0, 0, 0, 1, 1'b0);
    wait_idle();

    // Consumer stalls for five cycles, accepts on the sixth.
    bus.out_ready = 1'b0;
    send(12, 18, 2, 3, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("stall_valid_timeout", 0, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_in_ready", int'(bus.in_ready), 1);
    chk("post_hs_out_valid", int'(bus.out_valid), 0);

    // Reset in the middle of the numerator division abandons the transaction.
    send(12, 18, 2, 3, 0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    send(4, 8, 1, 2, 0, 1'b0);
    wait_idle();

    // Back-to-back pairs with in_valid held high.
    send(9, 6, 3, 2, 0, 1'b1);
    send(10, 4, 5, 2, 0, 1'b1);
    send(0, 3, 0, 1, 0, 1'b0);
    wait_idle();

    chk("drain", exp_q.size(), 0);
    chk("gcd_starts", starts, exp_starts);
    chk("gcd_pending", gexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frac_reduce.md
Name: frac_reduce

Overview:
Fraction-reduction stage that consumes the subtractive GCD engine's result. Accepts a numerator/denominator pair, drives the GCD engine through its start/ready handshake, and divides both operands by the returned GCD with a shared sequential restoring divider. Presents the reduced pair on a valid/ready output. Sits directly downstream of the GCD engine and is the only master of that engine's start/ina/inb inputs.

Parameters:
W, 8, operand and result width. Must match the GCD engine width.

Ports:
clk  input  1  clock, rising edge
nrst  input  1  reset, asynchronous, active-low
in_valid  input  1  input pair valid
in_ready  output  1  block can accept a pair; high only in IDLE
num  input  W  numerator, unsigned
den  input  W  denominator, unsigned
gcd_start  output  1  one-cycle start pulse to the GCD engine
gcd_ina  output  W  GCD operand A
gcd_inb  output  W  GCD operand B
gcd_ready  input  1  GCD engine ready; gcd_out is valid when this returns high
gcd_out  input  W  GCD result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_num  output  W  reduced numerator
out_den  output  W  reduced denominator
out_err  output  1  denominator was zero

Behaviour:
- Reset (async, nrst low): state IDLE. in_ready=1. gcd_start=0. gcd_ina=gcd_inb=0. out_valid=0. out_num=out_den=0. out_err=0. Divider regs and counter cleared. Reset mid-operation abandons the transaction with no output. The GCD engine shares nrst.
- States: IDLE, GCD_START, GCD_WAIT, DIV_NUM, DIV_DEN, OUT.
- IDLE: in_ready=1. On in_valid & in_ready, capture num/den into n_r/d_r. Then:
  - den==0: out_num=num, out_den=0, out_err=1, go to OUT. No GCD request.
  - else num==0: out_num=0, out_den=1, out_err=0, go to OUT. No GCD request; the engine never terminates on a zero operand.
  - else: go to GCD_START.
- GCD_START (1 cycle):
  - gcd_start=1.
  - gcd_ina=n_r, gcd_inb=d_r, both registered and held stable from entry to GCD_START until leaving GCD_WAIT.
  - Next state GCD_WAIT.
- GCD_WAIT:
  - gcd_start=0.
  - The first cycle of GCD_WAIT ignores gcd_ready, because the engine drops ready on the edge that samples start.
  - From the second cycle on, when gcd_ready=1, latch g=gcd_out and go to DIV_NUM.
  - No timeout.
- DIV_NUM: restoring division n_r / g.
  - Exactly W cycles, MSB-first, with a W+1-bit partial remainder.
  - Quotient goes to out_num. The remainder is always 0 and is discarded.
  - Then go to DIV_DEN.
- DIV_DEN: same divider and same W cycles for d_r / g. Quotient goes to out_den. Then go to OUT.
- OUT:
  - out_valid=1. out_num, out_den and out_err are held stable while out_valid & !out_ready.
  - On out_ready, go to IDLE. out_valid drops the next cycle; out_err clears on the next accept.
- in_ready=0 in every state except IDLE. No accept is possible in the same cycle as an output handshake. Minimum gap between accepts is 2 cycles on the zero paths.
- Latency, accept edge to out_valid (nonzero path): 1 (GCD_START) + T_gcd + 2W + 1, where T_gcd is the number of GCD_WAIT cycles. Zero paths: out_valid the cycle after accept.
- Results satisfy out_num*g==n_r and out_den*g==d_r, with gcd(out_num, out_den)=1.
- All arithmetic is unsigned W-bit; no overflow is possible.

Test Plan:
- Reset, then num=12, den=18, out_ready=1 -> exactly one gcd_start pulse with gcd_ina=12, gcd_inb=18. The model returns gcd_out=6 with gcd_ready high after 4 cycles. Result out_num=2, out_den=3, out_err=0, out_valid exactly 1+4+16+1 cycles after accept.
- num=7, den=7 -> out_num=1, out_den=1. num=255, den=17 -> gcd 17, out_num=15, out_den=1.
- num=0, den=5 -> no gcd_start. out_num=0, out_den=1, out_valid one cycle after accept. num=5, den=0 -> out_err=1, out_num=5, out_den=0, no gcd_start.
- Result 2/3 with out_ready held low 5 cycles -> out_valid and outputs held stable and in_ready=0 throughout. Handshake on cycle 6, then in_ready=1 the next cycle.
- Drop nrst mid-DIV_NUM -> all outputs return to reset values immediately. A following 4/8 transaction yields 1/2.
- Back-to-back pairs 9/6, 10/4, 0/3 with in_valid held high -> 3/2, 5/2, 0/1 in order. Each accepted only in IDLE, no pair dropped or duplicated.
